// File: rtl/int_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : int_wb_arbiter
//  Description : Round-robin write-back arbiter for the integer register file
//                write port, with a pending-write scoreboard that raises a
//                RAW/WAW hazard flag for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic                       issue_valid_i,
    input  logic [ADDR_W-1:0]          issue_addr_i,
    input  logic [ADDR_W-1:0]          rs_a_addr_i,
    input  logic [ADDR_W-1:0]          rs_b_addr_i,
    input  logic                       flush_i,
    output logic                       hazard_o,
    output logic                       rf_write_enable_o,
    output logic [ADDR_W-1:0]          rf_write_addr_o,
    output logic [DATA_W-1:0]          rf_write_data_o,
    output logic [(1<<ADDR_W)-1:0]     pending_o
);

    localparam int                 c_nreg     = 1 << ADDR_W;
    localparam int                 c_ptr_w    = $clog2(NUM_REQ);
    localparam logic [c_ptr_w-1:0] c_last_req = c_ptr_w'(NUM_REQ - 1);

    // Round-robin pointer, registered write port and scoreboard state
    logic [c_ptr_w-1:0] rr_ptr_q,  rr_ptr_d;
    logic               wen_q,     wen_d;
    logic [ADDR_W-1:0]  waddr_q,   waddr_d;
    logic [DATA_W-1:0]  wdata_q,   wdata_d;
    logic [c_nreg-1:0]  pending_q, pending_d;

    // Combinational arbitration results
    logic [NUM_REQ-1:0] w_grant;
    logic [c_ptr_w-1:0] w_grant_idx;
    logic               w_found;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;

    // Pick the first valid requester at or after the pointer, wrapping around;
    // the outer loop is the search distance so the nearest requester wins.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_found && req_valid_i[k] &&
                    (((int'(rr_ptr_q) + i) % NUM_REQ) == k)) begin
                    w_found     = 1'b1;
                    w_grant[k]  = 1'b1;
                    w_grant_idx = c_ptr_w'(k);
                    w_sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
                    w_sel_data  = req_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next pointer and write-port register: a grant is always a transfer
    // because it is only ever given to a valid requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (w_found) begin
            rr_ptr_d = (w_grant_idx == c_last_req) ? '0 : w_grant_idx + 1'b1;
            // x0 writes are consumed but never reach the register file
            wen_d    = (w_sel_addr != '0);
            waddr_d  = w_sel_addr;
            wdata_d  = w_sel_data;
        end
    end

    // Scoreboard: flush or commit clears first, then a new issue sets, so a
    // same-edge issue always survives.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else if (wen_q) begin
            pending_d[waddr_q] = 1'b0;
        end
        if (issue_valid_i && (issue_addr_i != '0)) begin
            pending_d[issue_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset discards any write still in the output stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    // Stall decode on a pending source (RAW) or a pending destination (WAW)
    always_comb begin
        hazard_o = (pending_q[rs_a_addr_i]  && (rs_a_addr_i  != '0)) ||
                   (pending_q[rs_b_addr_i]  && (rs_b_addr_i  != '0)) ||
                   (issue_valid_i && pending_q[issue_addr_i] && (issue_addr_i != '0));
    end

    assign req_ready_o       = w_grant;
    assign rf_write_enable_o = wen_q;
    assign rf_write_addr_o   = waddr_q;
    assign rf_write_data_o   = wdata_q;
    assign pending_o         = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_wb_arbiter
//  Description : Self-checking bench for int_wb_arbiter: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      issue_valid;
    logic [ADDR_W-1:0]         issue_addr;
    logic [ADDR_W-1:0]         rs_a;
    logic [ADDR_W-1:0]         rs_b;
    logic                      flush;
    logic                      hazard;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_addr;
    logic [DATA_W-1:0]         rf_data;
    logic [31:0]               pending;

    int n_checks = 0;
    int n_errors = 0;

    int_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_addr_i        (req_addr),
        .req_data_i        (req_data),
        .req_ready_o       (req_ready),
        .issue_valid_i     (issue_valid),
        .issue_addr_i      (issue_addr),
        .rs_a_addr_i       (rs_a),
        .rs_b_addr_i       (rs_b),
        .flush_i           (flush),
        .hazard_o          (hazard),
        .rf_write_enable_o (rf_we),
        .rf_write_addr_o   (rf_addr),
        .rf_write_data_o   (rf_data),
        .pending_o         (pending)
    );

    always #5 clk = ~clk;

    // Decode must never issue to a register still pending, unless that
    // register's write commits on this very edge.
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_addr != '0 && pending[issue_addr] &&
            !(rf_we && rf_addr == issue_addr)) begin
            n_errors++;
            $display("FAIL waw_issue: issue to pending r%0d", issue_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[k]                = v;
        req_addr[k*ADDR_W +: ADDR_W] = a;
        req_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 1'b0; issue_addr = '0; rs_a = '0; rs_b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 3'b000) begin n_errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
        n_checks++; if (rf_addr !== '0 || rf_data !== '0) begin n_errors++; $display("FAIL reset_addr_data: got %0d/%0h want 0/0", rf_addr, rf_data); end
        n_checks++; if (pending !== 32'h0) begin n_errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        n_checks++; if (hazard !== 1'b0) begin n_errors++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    endtask

    task automatic test_round_robin();
        set_req(0, 1'b1, 5'd1, 32'hA);
        set_req(1, 1'b1, 5'd2, 32'hB);
        set_req(2, 1'b1, 5'd3, 32'hC);
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL rr_first: got %b want 001", req_ready); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 5) req_valid = '0;
            n_checks++;
            if (rf_we !== 1'b1 || rf_addr !== ADDR_W'(c % 3 + 1) || rf_data !== DATA_W'(32'hA + c % 3)) begin
                n_errors++;
                $display("FAIL rr_write%0d: got we=%b r%0d=%0h want r%0d=%0h", c, rf_we, rf_addr, rf_data, c % 3 + 1, 32'hA + c % 3);
            end
            if (c < 5) begin
                n_checks++;
                if (req_ready !== NUM_REQ'(1 << ((c + 1) % 3))) begin
                    n_errors++; $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, NUM_REQ'(1 << ((c + 1) % 3)));
                end
            end
        end
        tick();
        n_checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd3 || rf_data !== 32'hC) begin n_errors++; $display("FAIL rr_hold: got we=%b r%0d=%0h want 0 r3=c", rf_we, rf_addr, rf_data); end
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1; issue_addr = 5'd5;
        #1;
        n_checks++; if (hazard !== 1'b0) begin n_errors++; $display("FAIL hz_issue: got %b want 0", hazard); end
        tick();
        issue_valid = 1'b0; rs_a = 5'd5;
        #1;
        n_checks++; if (hazard !== 1'b1 || pending !== 32'h20) begin n_errors++; $display("FAIL hz_raw: got hz=%b pend=%h want 1/20", hazard, pending); end
        set_req(1, 1'b1, 5'd5, 32'h1234);
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_errors++; $display("FAIL hz_grant: got %b want 010", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h1234 || hazard !== 1'b1) begin
            n_errors++; $display("FAIL hz_write: got we=%b r%0d=%0h hz=%b want 1 r5=1234 hz=1", rf_we, rf_addr, rf_data, hazard); end
        tick();
        n_checks++; if (rf_we !== 1'b0 || pending !== 32'h0 || hazard !== 1'b0) begin
            n_errors++; $display("FAIL hz_clear: got we=%b pend=%h hz=%b want 0/0/0", rf_we, pending, hazard); end
        rs_a = '0;
    endtask

    task automatic test_x0();
        // pointer sits at 2 after the previous grant to requester 1
        set_req(2, 1'b1, 5'd0, 32'hFFFF);
        set_req(0, 1'b1, 5'd4, 32'h44);
        #1;
        n_checks++; if (req_ready !== 3'b100) begin n_errors++; $display("FAIL x0_grant: got %b want 100", req_ready); end
        tick();
        set_req(2, 1'b1, 5'd9, 32'h99);
        #1;
        n_checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'hFFFF) begin
            n_errors++; $display("FAIL x0_write: got we=%b r%0d=%0h want 0 r0=ffff", rf_we, rf_addr, rf_data); end
        n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL x0_ptr: got %b want 001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd4 || req_ready !== 3'b100) begin
            n_errors++; $display("FAIL x0_next: got we=%b r%0d rdy=%b want 1 r4 100", rf_we, rf_addr, req_ready); end
        tick();
        req_valid = '0;
        tick();
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        n_checks++; if (hazard !== 1'b0) begin n_errors++; $display("FAIL x0_issue_hz: got %b want 0", hazard); end
        tick();
        issue_valid = 1'b0;
        n_checks++; if (pending !== 32'h0) begin n_errors++; $display("FAIL x0_issue_pend: got %h want 0", pending); end
    endtask

    task automatic test_same_edge_flush();
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        set_req(0, 1'b1, 5'd7, 32'h77);
        #1;
        n_checks++; if (req_ready !== 3'b001 || pending !== 32'h80) begin
            n_errors++; $display("FAIL se_setup: got rdy=%b pend=%h want 001/80", req_ready, pending); end
        tick();
        req_valid = '0;
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || hazard !== 1'b1) begin
            n_errors++; $display("FAIL se_commit: got we=%b r%0d hz=%b want 1 r7 1", rf_we, rf_addr, hazard); end
        tick();
        issue_valid = 1'b0;
        n_checks++; if (pending !== 32'h80) begin n_errors++; $display("FAIL se_setwins: got %h want 80", pending); end
        issue_valid = 1'b1; issue_addr = 5'd3; tick();
        issue_addr = 5'd4; tick();
        issue_valid = 1'b0;
        n_checks++; if (pending !== 32'h98) begin n_errors++; $display("FAIL fl_before: got %h want 98", pending); end
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++; if (pending !== 32'h0) begin n_errors++; $display("FAIL fl_clear: got %h want 0", pending); end
        flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd6; tick();
        flush = 1'b0; issue_valid = 1'b0;
        n_checks++; if (pending !== 32'h40) begin n_errors++; $display("FAIL fl_setwins: got %h want 40", pending); end
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        // pointer sits at 1 after the r7 write by requester 0
        issue_valid = 1'b1; issue_addr = 5'd9; tick(); issue_valid = 1'b0;
        set_req(1, 1'b1, 5'd8, 32'h88);
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_errors++; $display("FAIL rm_grant: got %b want 010", req_ready); end
        tick();
        req_valid = '0;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0 || rf_addr !== '0 || rf_data !== '0 || pending !== 32'h0 || hazard !== 1'b0) begin
            n_errors++; $display("FAIL rm_async: got we=%b r%0d=%0h pend=%h hz=%b want all 0", rf_we, rf_addr, rf_data, pending, hazard); end
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 5'd1, 32'h1);
        set_req(1, 1'b1, 5'd2, 32'h2);
        set_req(2, 1'b1, 5'd3, 32'h3);
        #1;
        n_checks++; if (req_ready !== 3'b001 || rf_we !== 1'b0) begin
            n_errors++; $display("FAIL rm_restart: got rdy=%b we=%b want 001/0", req_ready, rf_we); end
        req_valid = '0;
    endtask

    // Randomized traffic against a model built directly from the arbitration,
    // output-stage and scoreboard rules.
    task automatic test_random();
        logic [NUM_REQ-1:0] v;
        logic [ADDR_W-1:0]  a [NUM_REQ];
        logic [DATA_W-1:0]  d [NUM_REQ];
        int                 m_ptr, g;
        logic               m_wen, old_wen, raw, iss, exp_haz;
        logic [ADDR_W-1:0]  m_waddr, old_waddr, cand;
        logic [DATA_W-1:0]  m_wdata;
        logic [31:0]        m_pend;
        logic [NUM_REQ-1:0] exp_ready;
        rst = 1'b1; req_valid = '0; issue_valid = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b0;
        v = '0; m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_pend = '0;
        for (int k = 0; k < NUM_REQ; k++) begin a[k] = '0; d[k] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!v[k] && $urandom_range(0, 2) != 0) begin
                    v[k] = 1'b1;
                    a[k] = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
                    d[k] = $urandom;
                end
                set_req(k, v[k], a[k], d[k]);
            end
            rs_a  = ADDR_W'($urandom_range(0, 31));
            rs_b  = ADDR_W'($urandom_range(0, 31));
            flush = ($urandom_range(0, 19) == 0);
            cand  = ADDR_W'($urandom_range(0, 31));
            raw   = (rs_a != 0 && m_pend[rs_a]) || (rs_b != 0 && m_pend[rs_b]);
            iss   = !raw && !(cand != 0 && m_pend[cand]) && ($urandom_range(0, 1) == 1);
            issue_valid = iss; issue_addr = cand;
            #1;
            g = -1;
            for (int i = 0; i < NUM_REQ; i++)
                if (g < 0 && v[(m_ptr + i) % NUM_REQ]) g = (m_ptr + i) % NUM_REQ;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_haz = raw || (iss && cand != 0 && m_pend[cand]);
            n_checks++; if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, exp_ready); end
            n_checks++; if (hazard !== exp_haz) begin n_errors++; $display("FAIL rnd_hazard@%0d: got %b want %b", cyc, hazard, exp_haz); end
            n_checks++; if (rf_we !== m_wen || rf_addr !== m_waddr || rf_data !== m_wdata) begin
                n_errors++; $display("FAIL rnd_write@%0d: got %b r%0d=%h want %b r%0d=%h", cyc, rf_we, rf_addr, rf_data, m_wen, m_waddr, m_wdata); end
            n_checks++; if (pending !== m_pend) begin n_errors++; $display("FAIL rnd_pending@%0d: got %h want %h", cyc, pending, m_pend); end
            old_wen = m_wen; old_waddr = m_waddr;
            if (g >= 0) begin
                m_wen = (a[g] != 0); m_waddr = a[g]; m_wdata = d[g];
                m_ptr = (g + 1) % NUM_REQ;
                v[g] = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            if (flush) m_pend = '0;
            else if (old_wen) m_pend[old_waddr] = 1'b0;
            if (iss && cand != 0) m_pend[cand] = 1'b1;
            tick();
        end
        req_valid = '0; issue_valid = 1'b0; flush = 1'b0; rs_a = '0; rs_b = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_hazard();
        test_x0();
        test_same_edge_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
